// File: rtl/wm_cycle_controller_pkg.sv
// Shared definitions for the washing-machine cycle controller:
// phase codes (also consumed by Timer) and the actuator bit layout.
package wm_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FILL  = 3'd1;
   localparam logic [2:0] ST_HEAT  = 3'd2;
   localparam logic [2:0] ST_WASH  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;
   localparam logic [2:0] ST_RINSE = 3'd5;
   localparam logic [2:0] ST_SPIN  = 3'd6;
   localparam logic [2:0] ST_DONE  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_FILL  = ST_FILL,
      S_HEAT  = ST_HEAT,
      S_WASH  = ST_WASH,
      S_DRAIN = ST_DRAIN,
      S_RINSE = ST_RINSE,
      S_SPIN  = ST_SPIN,
      S_DONE  = ST_DONE
   } wm_state_e;

   localparam int ACT_WATER  = 0;
   localparam int ACT_HEATER = 1;
   localparam int ACT_MOTOR  = 2;
   localparam int ACT_SPIN   = 3;
   localparam int ACT_DRAIN  = 4;
   localparam int ACT_LOCK   = 5;
   localparam int ACT_W      = 6;

   typedef logic [ACT_W-1:0] act_vec_t;

   // Phases in which the door is locked and cancel / door-open abort to DRAIN.
   function automatic logic is_active(input wm_state_e st);
      logic act;
      case (st)
         S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: act = 1'b1;
         default:                                 act = 1'b0;
      endcase
      return act;
   endfunction

   function automatic act_vec_t act_decode(input wm_state_e st);
      act_vec_t a;
      a = {ACT_W{1'b0}};
      case (st)
         S_FILL:  a[ACT_WATER]  = 1'b1;
         S_HEAT:  a[ACT_HEATER] = 1'b1;
         S_WASH:  a[ACT_MOTOR]  = 1'b1;
         S_RINSE: a[ACT_MOTOR]  = 1'b1;
         S_DRAIN: a[ACT_DRAIN]  = 1'b1;
         S_SPIN: begin
            a[ACT_MOTOR] = 1'b1;
            a[ACT_SPIN]  = 1'b1;
            a[ACT_DRAIN] = 1'b1;
         end
         default: a = {ACT_W{1'b0}};
      endcase
      a[ACT_LOCK] = (st != S_IDLE) && (st != S_DONE);
      return a;
   endfunction

endpackage

// File: rtl/wm_cycle_controller_phase_watchdog.sv
// Saturating per-phase cycle counter; expired rises once the current phase
// has lasted `limit` cycles (counting the cycle in which the decision is made).
module phase_watchdog #(
   parameter int TO_W = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            clear,
   input  logic [TO_W-1:0] limit,
   output logic            expired
);

   localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
   localparam logic [TO_W:0]   ELP_ONE = {{TO_W{1'b0}}, 1'b1};

   logic [TO_W-1:0] count_q;
   logic [TO_W-1:0] count_d;
   logic [TO_W:0]   elapsed_s;

   // Next count and expiry; the extra bit keeps count+1 from wrapping at saturation.
   always_comb begin
      count_d   = count_q;
      elapsed_s = {1'b0, count_q} + ELP_ONE;
      if (clear) begin
         count_d = {TO_W{1'b0}};
      end else if (count_q != CNT_MAX) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
      expired = (elapsed_s >= {1'b0, limit});
   end

   // Counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= {TO_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wm_cycle_controller.sv
// Wash-cycle sequencer: phase FSM, rinse-pass counting, watchdogs, cancel and
// door interlock, with actuator enables registered from the next state.
module wm_cycle_controller
   import wm_pkg::*;
#(
   parameter int RINSE_PASSES = 2,
   parameter int TO_W         = 16,
   parameter int FILL_TIMEOUT = 1000,
   parameter int HEAT_TIMEOUT = 4000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       cancel,
   input  logic       door_closed,
   input  logic       sig_Full,
   input  logic       sig_Temperature,
   input  logic       sig_Completed,
   output logic [2:0] state,
   output logic       water_valve,
   output logic       heater,
   output logic       motor,
   output logic       spin_fast,
   output logic       drain_pump,
   output logic       door_lock,
   output logic       done,
   output logic       fault,
   output logic       aborted
);

   localparam logic [TO_W-1:0] FILL_LIM   = TO_W'(FILL_TIMEOUT);
   localparam logic [TO_W-1:0] HEAT_LIM   = TO_W'(HEAT_TIMEOUT);
   localparam logic [2:0]      PASS_LIMIT = 3'(RINSE_PASSES);

   wm_state_e       state_q, state_d;
   logic [2:0]      pass_cnt_q, pass_cnt_d;
   logic            wash_done_q, wash_done_d;
   logic            fault_q, fault_d;
   logic            aborted_q, aborted_d;
   logic            first_q, first_d;
   act_vec_t        act_q, act_d;
   logic            done_q, done_d;

   logic            ev_ok_s;
   logic            wd_clear_s;
   logic            wd_expired_s;
   logic            wd_hit_s;
   logic [TO_W-1:0] wd_limit_s;

   // Watchdog limit for the current phase; other phases never consult it.
   always_comb begin
      case (state_q)
         S_FILL:  wd_limit_s = FILL_LIM;
         S_HEAT:  wd_limit_s = HEAT_LIM;
         default: wd_limit_s = {TO_W{1'b1}};
      endcase
   end

   phase_watchdog #(
      .TO_W (TO_W)
   ) u_watchdog (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (wd_clear_s),
      .limit   (wd_limit_s),
      .expired (wd_expired_s)
   );

   // Next-state, sticky flags and pass counter. Timer events are masked on the
   // first cycle of a phase so a stale pulse from the previous phase is dropped.
   always_comb begin
      state_d     = state_q;
      pass_cnt_d  = pass_cnt_q;
      wash_done_d = wash_done_q;
      fault_d     = fault_q;
      aborted_d   = aborted_q;
      ev_ok_s     = !first_q;
      wd_hit_s    = wd_expired_s && ((state_q == S_FILL) || (state_q == S_HEAT));

      if (is_active(state_q)) begin
         if (!door_closed) begin
            state_d = S_DRAIN;
            fault_d = 1'b1;
         end else if (cancel) begin
            state_d   = S_DRAIN;
            aborted_d = 1'b1;
         end else if (wd_hit_s) begin
            state_d = S_DRAIN;
            fault_d = 1'b1;
         end else if (ev_ok_s) begin
            case (state_q)
               S_FILL: begin
                  if (sig_Full) begin
                     state_d = ((pass_cnt_q == 3'd0) && !wash_done_q) ? S_HEAT : S_RINSE;
                  end else begin
                     state_d = state_q;
                  end
               end
               S_HEAT: begin
                  if (sig_Temperature) begin
                     state_d = S_WASH;
                  end else begin
                     state_d = state_q;
                  end
               end
               S_WASH: begin
                  if (sig_Completed) begin
                     state_d     = S_DRAIN;
                     wash_done_d = 1'b1;
                  end else begin
                     state_d = state_q;
                  end
               end
               S_RINSE: begin
                  if (sig_Completed) begin
                     state_d = S_DRAIN;
                     if (pass_cnt_q != 3'd7) begin
                        pass_cnt_d = pass_cnt_q + 3'd1;
                     end else begin
                        pass_cnt_d = pass_cnt_q;
                     end
                  end else begin
                     state_d = state_q;
                  end
               end
               S_SPIN: begin
                  if (sig_Completed) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = state_q;
                  end
               end
               default: state_d = state_q;
            endcase
         end else begin
            state_d = state_q;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && door_closed) begin
                  state_d     = S_FILL;
                  pass_cnt_d  = 3'd0;
                  wash_done_d = 1'b0;
                  fault_d     = 1'b0;
                  aborted_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DRAIN: begin
               if (ev_ok_s && sig_Completed) begin
                  if (fault_q || aborted_q) begin
                     state_d = S_DONE;
                  end else if (pass_cnt_q < PASS_LIMIT) begin
                     state_d = S_FILL;
                  end else begin
                     state_d = S_SPIN;
                  end
               end else begin
                  state_d = S_DRAIN;
               end
            end
            S_DONE: begin
               if (!door_closed) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      wd_clear_s = (state_d != state_q);
      first_d    = wd_clear_s;
      act_d      = act_decode(state_d);
      done_d     = (state_d == S_DONE);
   end

   // State, flags and registered output decode.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         pass_cnt_q  <= 3'd0;
         wash_done_q <= 1'b0;
         fault_q     <= 1'b0;
         aborted_q   <= 1'b0;
         first_q     <= 1'b1;
         act_q       <= {ACT_W{1'b0}};
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pass_cnt_q  <= pass_cnt_d;
         wash_done_q <= wash_done_d;
         fault_q     <= fault_d;
         aborted_q   <= aborted_d;
         first_q     <= first_d;
         act_q       <= act_d;
         done_q      <= done_d;
      end
   end

   assign state       = state_q;
   assign water_valve = act_q[ACT_WATER];
   assign heater      = act_q[ACT_HEATER];
   assign motor       = act_q[ACT_MOTOR];
   assign spin_fast   = act_q[ACT_SPIN];
   assign drain_pump  = act_q[ACT_DRAIN];
   assign door_lock   = act_q[ACT_LOCK];
   assign done        = done_q;
   assign fault       = fault_q;
   assign aborted     = aborted_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Self-checking bench for wm_cycle_controller: directed scenarios plus random
// stimulus, all compared against a phase-level behavioural model.
module tb_wm_cycle_controller;

   localparam int RP      = 1;
   localparam int FILL_TO = 8;
   localparam int HEAT_TO = 20;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic       door_closed = 1'b1;
   logic       sig_Full = 1'b0;
   logic       sig_Temperature = 1'b0;
   logic       sig_Completed = 1'b0;
   logic [2:0] state;
   logic       water_valve, heater, motor, spin_fast, drain_pump, door_lock;
   logic       done, fault, aborted;
   logic [11:0] dut_vec;

   int checks = 0;
   int errors = 0;

   // behavioural model: phase number, cycles since phase entry, rinses done
   int m_state, m_age, m_pass;
   bit m_washed, m_fault, m_abort;
   bit auto_ev = 1'b0;

   wm_cycle_controller #(
      .RINSE_PASSES (RP),
      .TO_W         (16),
      .FILL_TIMEOUT (FILL_TO),
      .HEAT_TIMEOUT (HEAT_TO)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .cancel          (cancel),
      .door_closed     (door_closed),
      .sig_Full        (sig_Full),
      .sig_Temperature (sig_Temperature),
      .sig_Completed   (sig_Completed),
      .state           (state),
      .water_valve     (water_valve),
      .heater          (heater),
      .motor           (motor),
      .spin_fast       (spin_fast),
      .drain_pump      (drain_pump),
      .door_lock       (door_lock),
      .done            (done),
      .fault           (fault),
      .aborted         (aborted)
   );

   always #5 clock = ~clock;

   assign dut_vec = {state, water_valve, heater, motor, spin_fast, drain_pump,
                     door_lock, done, fault, aborted};

   function automatic logic [11:0] exp_vec();
      logic [2:0] s;
      s = 3'(m_state);
      return {s, m_state == 1, m_state == 2, (m_state == 3 || m_state == 5 || m_state == 6),
              m_state == 6, (m_state == 4 || m_state == 6), (m_state != 0 && m_state != 7),
              m_state == 7, m_fault, m_abort};
   endfunction

   task automatic model_reset();
      m_state = 0; m_age = 0; m_pass = 0;
      m_washed = 1'b0; m_fault = 1'b0; m_abort = 1'b0;
   endtask

   task automatic model_step();
      int  nxt;
      bit  active;
      nxt    = m_state;
      active = (m_state == 1 || m_state == 2 || m_state == 3 || m_state == 5 || m_state == 6);
      if (m_state == 0) begin
         if (start && door_closed) begin
            nxt = 1; m_pass = 0; m_washed = 1'b0; m_fault = 1'b0; m_abort = 1'b0;
         end
      end else if (active) begin
         if (!door_closed) begin
            nxt = 4; m_fault = 1'b1;
         end else if (cancel) begin
            nxt = 4; m_abort = 1'b1;
         end else if ((m_state == 1 && m_age + 1 >= FILL_TO) ||
                      (m_state == 2 && m_age + 1 >= HEAT_TO)) begin
            nxt = 4; m_fault = 1'b1;
         end else if (m_age > 0) begin
            if (m_state == 1 && sig_Full) nxt = m_washed ? 5 : 2;
            if (m_state == 2 && sig_Temperature) nxt = 3;
            if (m_state == 3 && sig_Completed) begin nxt = 4; m_washed = 1'b1; end
            if (m_state == 5 && sig_Completed) begin nxt = 4; m_pass++; end
            if (m_state == 6 && sig_Completed) nxt = 7;
         end
      end else if (m_state == 4) begin
         if (m_age > 0 && sig_Completed)
            nxt = (m_fault || m_abort) ? 7 : ((m_pass < RP) ? 1 : 6);
      end else if (m_state == 7) begin
         if (!door_closed) nxt = 0;
      end
      m_age   = (nxt != m_state) ? 0 : m_age + 1;
      m_state = nxt;
   endtask

   // One clock: optionally pulse the Timer event 3 cycles into the phase.
   task automatic tick();
      if (auto_ev) begin
         sig_Full        = (m_state == 1 && m_age == 2);
         sig_Temperature = (m_state == 2 && m_age == 2);
         sig_Completed   = (m_age == 2 && (m_state == 3 || m_state == 4 ||
                                           m_state == 5 || m_state == 6));
      end
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic run_to(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (m_state == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (dut_vec !== 12'h000) begin
         errors++; $display("FAIL reset_vec got %h want %h", dut_vec, 12'h000);
      end
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++; $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_normal_cycle();
      int seq[$];
      int exp_seq[10] = '{0, 1, 2, 3, 4, 1, 5, 4, 6, 7};
      auto_ev = 1'b1;
      seq.push_back(int'(state));
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (state !== 3'd1 || water_valve !== 1'b1) begin
         errors++; $display("FAIL start_latency got state=%0d wv=%b want 1/1", state, water_valve);
      end
      seq.push_back(int'(state));
      for (int i = 0; i < 200 && m_state != 7; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL normal_cycle got %h want %h", dut_vec, exp_vec());
         end
         if (int'(state) != seq[$]) seq.push_back(int'(state));
      end
      checks++;
      if (seq.size() != 10) begin
         errors++; $display("FAIL normal_seq_len got %0d want 10", seq.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (seq[i] != exp_seq[i]) begin
               errors++; $display("FAIL normal_seq[%0d] got %0d want %0d", i, seq[i], exp_seq[i]);
            end
         end
      end
      checks++;
      if ({done, door_lock, fault, aborted} !== 4'b1000) begin
         errors++; $display("FAIL normal_done_flags got %b want 1000", {done, door_lock, fault, aborted});
      end
      door_closed = 1'b0;
      tick();
      door_closed = 1'b1;
      checks++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL done_to_idle got %0d want 0", state);
      end
      auto_ev = 1'b0;
   endtask

   task automatic test_door_open_start();
      bit ok;
      door_closed = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (dut_vec !== 12'h000) begin
            errors++; $display("FAIL open_door_start got %h want %h", dut_vec, 12'h000);
         end
      end
      door_closed = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL door_close_fill got %0d want 1", state);
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++;
      if (dut_vec !== exp_vec() || aborted !== 1'b1 || state !== 3'd4) begin
         errors++; $display("FAIL cancel_fill got %h want %h", dut_vec, exp_vec());
      end
      auto_ev = 1'b1;
      run_to(7, 50, ok);
      auto_ev = 1'b0;
      checks++;
      if (!ok || state !== 3'd7) begin
         errors++; $display("FAIL cancel_fill_done got %0d want 7", state);
      end
      door_closed = 1'b0;
      tick();
      door_closed = 1'b1;
   endtask

   task automatic test_cancel_wash();
      bit ok;
      bit saw_rinse;
      auto_ev = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to(3, 60, ok);
      auto_ev = 1'b0;
      tick();
      cancel = 1'b1;
      sig_Completed = 1'b1;
      tick();
      cancel = 1'b0;
      sig_Completed = 1'b0;
      checks++;
      if (!ok || state !== 3'd4 || aborted !== 1'b1 || fault !== 1'b0) begin
         errors++; $display("FAIL cancel_wash got state=%0d ab=%b want 4/1", state, aborted);
      end
      saw_rinse = 1'b0;
      auto_ev = 1'b1;
      for (int i = 0; i < 50 && m_state != 7; i++) begin
         tick();
         if (state === 3'd5) saw_rinse = 1'b1;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL cancel_drain got %h want %h", dut_vec, exp_vec());
         end
      end
      auto_ev = 1'b0;
      checks++;
      if (saw_rinse || state !== 3'd7 || done !== 1'b1) begin
         errors++; $display("FAIL cancel_done got state=%0d rinse=%b want 7/0", state, saw_rinse);
      end
      door_closed = 1'b0;
      tick();
      door_closed = 1'b1;
      checks++;
      if (state !== 3'd0 || aborted !== 1'b1) begin
         errors++; $display("FAIL aborted_sticky got state=%0d ab=%b want 0/1", state, aborted);
      end
   endtask

   task automatic test_fill_timeout();
      bit ok;
      int k;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      do begin
         tick();
         k++;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL fill_wd_cycle got %h want %h", dut_vec, exp_vec());
         end
      end while (state === 3'd1 && k < 30);
      checks++;
      if (k != FILL_TO || state !== 3'd4 || fault !== 1'b1 || water_valve !== 1'b0) begin
         errors++; $display("FAIL fill_timeout got k=%0d state=%0d f=%b want %0d/4/1", k, state, fault, FILL_TO);
      end
      auto_ev = 1'b1;
      run_to(7, 50, ok);
      auto_ev = 1'b0;
      checks++;
      if (!ok || state !== 3'd7 || fault !== 1'b1) begin
         errors++; $display("FAIL fill_wd_done got %0d want 7", state);
      end
      door_closed = 1'b0;
      tick();
      door_closed = 1'b1;
   endtask

   task automatic test_door_heat();
      bit ok;
      auto_ev = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to(2, 40, ok);
      auto_ev = 1'b0;
      tick();
      door_closed = 1'b0;
      tick();
      checks++;
      if (!ok || state !== 3'd4 || fault !== 1'b1 || heater !== 1'b0) begin
         errors++; $display("FAIL door_heat got state=%0d f=%b h=%b want 4/1/0", state, fault, heater);
      end
      auto_ev = 1'b1;
      run_to(7, 40, ok);
      auto_ev = 1'b0;
      checks++;
      if (!ok || state !== 3'd7) begin
         errors++; $display("FAIL door_heat_done got %0d want 7", state);
      end
      tick();
      checks++;
      if (state !== 3'd0 || fault !== 1'b1) begin
         errors++; $display("FAIL door_heat_idle got state=%0d f=%b want 0/1", state, fault);
      end
      door_closed = 1'b1;
   endtask

   task automatic test_reset_spin();
      bit ok;
      auto_ev = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to(6, 200, ok);
      auto_ev = 1'b0;
      sig_Full = 1'b0; sig_Temperature = 1'b0; sig_Completed = 1'b0;
      checks++;
      if (!ok || {motor, spin_fast, drain_pump} !== 3'b111) begin
         errors++; $display("FAIL reach_spin got state=%0d want 6", state);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || {motor, spin_fast, drain_pump, door_lock} !== 4'b0000) begin
         errors++; $display("FAIL async_reset got state=%0d acts=%b want 0/0000", state,
                            {motor, spin_fast, drain_pump, door_lock});
      end
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL post_reset_fill got %0d want 1", state);
      end
      tick();
      sig_Full = 1'b1;
      tick();
      sig_Full = 1'b0;
      checks++;
      if (state !== 3'd2 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL post_reset_heat got %0d want 2", state);
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      auto_ev = 1'b1;
      run_to(7, 40, ok);
      auto_ev = 1'b0;
      door_closed = 1'b0;
      tick();
      door_closed = 1'b1;
      checks++;
      if (!ok || state !== 3'd0) begin
         errors++; $display("FAIL reset_spin_tail got %0d want 0", state);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         start           = ($urandom_range(0, 3) == 0);
         cancel          = ($urandom_range(0, 63) == 0);
         door_closed     = ($urandom_range(0, 31) != 0);
         sig_Full        = ($urandom_range(0, 5) == 0);
         sig_Temperature = ($urandom_range(0, 5) == 0);
         sig_Completed   = ($urandom_range(0, 5) == 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL random[%0d] got %h want %h", i, dut_vec, exp_vec());
         end
      end
      start = 1'b0; cancel = 1'b0; door_closed = 1'b1;
      sig_Full = 1'b0; sig_Temperature = 1'b0; sig_Completed = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_cycle();
      test_door_open_start();
      test_cancel_wash();
      test_fill_timeout();
      test_door_heat();
      test_reset_spin();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
